// File: rtl/param_updown_counter_pkg.sv
// Shared definitions for the parameterised up/down counter: mode encodings
// and the default counter width.
package param_updown_counter_pkg;

    // Behaviour at a count boundary: wrap around or stick at the bound.
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage : param_updown_counter_pkg

// File: rtl/param_updown_counter_updown_next.sv
// Combinational next-value and boundary detection for the up/down counter.
// All arithmetic is done one bit wider than the counter so an increment from
// all-ones never aliases back to zero before the bound comparison.
module updown_next
    import param_updown_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             up_down_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic [WIDTH-1:0] next_count_o,
    output logic             boundary_o,
    output logic [WIDTH-1:0] load_clamped_o
);

    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] lim_ext;
    logic [WIDTH:0] ld_ext;
    logic [WIDTH:0] inc_ext;
    logic [WIDTH:0] dec_ext;
    logic [WIDTH:0] result_ext;

    assign cnt_ext = {1'b0, count_i};
    assign lim_ext = {1'b0, limit_i};
    assign ld_ext  = {1'b0, load_value_i};
    assign inc_ext = cnt_ext + {{WIDTH{1'b0}}, 1'b1};
    assign dec_ext = cnt_ext - {{WIDTH{1'b0}}, 1'b1};

    // Step the count one place in the requested direction, resolving the bound.
    always_comb begin
        result_ext = cnt_ext;
        boundary_o = 1'b0;
        if (up_down_i) begin
            if (cnt_ext >= lim_ext) begin
                boundary_o = 1'b1;
                result_ext = (mode_i == MODE_SAT) ? lim_ext : '0;
            end else begin
                result_ext = inc_ext;
            end
        end else begin
            // A count above a lowered limit just decrements; only zero is a bound.
            if (cnt_ext == '0) begin
                boundary_o = 1'b1;
                result_ext = (mode_i == MODE_SAT) ? '0 : lim_ext;
            end else begin
                result_ext = dec_ext;
            end
        end
    end

    // Loads never place the count above the current limit.
    always_comb begin
        load_clamped_o = (ld_ext > lim_ext) ? limit_i : load_value_i;
    end

    assign next_count_o = result_ext[WIDTH-1:0];

endmodule : updown_next

// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with wrap/saturate modes, inclusive upper
// limit, synchronous load, registered terminal-count pulse and sticky wrap flag.
module param_updown_counter
    import param_updown_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] step_count;
    logic             step_boundary;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] reset_count;

    updown_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .count_i        (count_q),
        .up_down_i      (up_down),
        .mode_i         (mode),
        .limit_i        (limit),
        .load_value_i   (load_value),
        .next_count_o   (step_count),
        .boundary_o     (step_boundary),
        .load_clamped_o (load_clamped)
    );

    // Counting up starts from zero; counting down starts from the limit.
    assign reset_count = up_down ? '0 : limit;

    // Select the next state by priority: load, then enabled count, then hold.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q & ~ovf_clr;
        if (load) begin
            count_d = load_clamped;
        end else if (enable) begin
            count_d = step_count;
            tc_d    = step_boundary;
            // A wrap sets the flag even when a clear arrives in the same cycle.
            if (step_boundary && (mode == MODE_WRAP)) begin
                ovf_d = 1'b1;
            end
        end
    end

    // State registers; reset overrides every other request.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= reset_count;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_out = count_q;
    assign tc        = tc_q;
    assign ovf       = ovf_q;

endmodule : param_updown_counter

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter (WIDTH=8): directed vector table followed by
// randomized stimulus checked against a behavioural model.
module tb_param_updown_counter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, enable, up_down, mode, load, ovf_clr;
    logic [W-1:0] limit, load_value;
    logic [W-1:0] count_out;
    logic         tc, ovf;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state.
    int m_cnt;
    bit m_tc, m_ovf;

    typedef struct {
        bit       rst, en, ud, md, ld, clr;
        int       lim, lv;
        int       e_cnt;
        bit       e_tc, e_ovf;
    } vec_t;

    vec_t vecs[$];

    param_updown_counter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .up_down    (up_down),
        .mode       (mode),
        .limit      (limit),
        .load       (load),
        .load_value (load_value),
        .ovf_clr    (ovf_clr),
        .count_out  (count_out),
        .tc         (tc),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic addv(input bit rst, input bit en, input bit ud, input bit md,
                        input int lim, input bit ld, input int lv, input bit clr,
                        input int e_cnt, input bit e_tc, input bit e_ovf);
        vec_t v;
        v.rst = rst; v.en = en; v.ud = ud; v.md = md; v.lim = lim;
        v.ld = ld; v.lv = lv; v.clr = clr;
        v.e_cnt = e_cnt; v.e_tc = e_tc; v.e_ovf = e_ovf;
        vecs.push_back(v);
    endtask

    task automatic drive(input bit rst, input bit en, input bit ud, input bit md,
                         input int lim, input bit ld, input int lv, input bit clr);
        reset = rst; enable = en; up_down = ud; mode = md;
        limit = W'(lim); load = ld; load_value = W'(lv); ovf_clr = clr;
    endtask

    task automatic check(input string name, input int exp_cnt, input bit exp_tc, input bit exp_ovf);
        n_cmp++;
        if (int'(count_out) !== exp_cnt || tc !== exp_tc || ovf !== exp_ovf) begin
            n_bad++;
            $display("FAIL %s: got count=%0d tc=%0b ovf=%0b, expected count=%0d tc=%0b ovf=%0b",
                     name, count_out, tc, ovf, exp_cnt, exp_tc, exp_ovf);
        end
    endtask

    // Apply one clock edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour written from the counter rules in plain integer math.
    task automatic model_edge();
        bit at_bound;
        if (reset) begin
            m_cnt = up_down ? 0 : int'(limit);
            m_tc  = 0;
            m_ovf = 0;
        end else if (load) begin
            m_cnt = (int'(load_value) < int'(limit)) ? int'(load_value) : int'(limit);
            m_tc  = 0;
            if (ovf_clr) m_ovf = 0;
        end else if (enable) begin
            if (ovf_clr) m_ovf = 0;
            if (up_down) begin
                at_bound = (m_cnt >= int'(limit));
                if (!at_bound)   m_cnt = m_cnt + 1;
                else if (mode)   m_cnt = int'(limit);
                else             m_cnt = 0;
            end else begin
                at_bound = (m_cnt == 0);
                if (!at_bound)   m_cnt = m_cnt - 1;
                else if (mode)   m_cnt = 0;
                else             m_cnt = int'(limit);
            end
            m_tc = at_bound;
            if (at_bound && !mode) m_ovf = 1;
        end else begin
            m_tc = 0;
            if (ovf_clr) m_ovf = 0;
        end
    endtask

    initial begin
        drive(0, 0, 1, 0, 255, 0, 0, 0);

        //    rst en ud md lim ld lv  clr   cnt tc ovf
        // Reset then four up counts.
        addv(1, 0, 1, 0, 255, 0, 0,   0,   0,  0, 0);
        addv(0, 1, 1, 0, 255, 0, 0,   0,   1,  0, 0);
        addv(0, 1, 1, 0, 255, 0, 0,   0,   2,  0, 0);
        addv(0, 1, 1, 0, 255, 0, 0,   0,   3,  0, 0);
        addv(0, 1, 1, 0, 255, 0, 0,   0,   4,  0, 0);
        // Wrap at limit 9.
        addv(0, 0, 1, 0, 9,   1, 8,   0,   8,  0, 0);
        addv(0, 1, 1, 0, 9,   0, 0,   0,   9,  0, 0);
        addv(0, 1, 1, 0, 9,   0, 0,   0,   0,  1, 1);
        addv(0, 0, 1, 0, 9,   0, 0,   0,   0,  0, 1);
        // Clear coincident with a wrap loses; clear alone wins.
        addv(0, 0, 1, 0, 9,   1, 9,   0,   9,  0, 1);
        addv(0, 1, 1, 0, 9,   0, 0,   1,   0,  1, 1);
        addv(0, 0, 1, 0, 9,   0, 0,   1,   0,  0, 0);
        // Saturating down count holding at zero.
        addv(0, 0, 0, 1, 9,   1, 1,   0,   1,  0, 0);
        addv(0, 1, 0, 1, 9,   0, 0,   0,   0,  0, 0);
        addv(0, 1, 0, 1, 9,   0, 0,   0,   0,  1, 0);
        addv(0, 1, 0, 1, 9,   0, 0,   0,   0,  1, 0);
        // Load clamp, and reset overriding load/enable/clear.
        addv(0, 0, 1, 0, 50,  1, 200, 0,   50, 0, 0);
        addv(1, 1, 0, 0, 50,  1, 10,  1,   50, 0, 0);
        addv(1, 1, 1, 0, 50,  1, 10,  0,   0,  0, 0);
        // All-ones wrap and limit zero.
        addv(0, 0, 1, 0, 255, 1, 255, 0,   255,0, 0);
        addv(0, 1, 1, 0, 255, 0, 0,   0,   0,  1, 1);
        addv(0, 1, 1, 0, 0,   0, 0,   0,   0,  1, 1);
        addv(0, 1, 1, 0, 0,   0, 0,   0,   0,  1, 1);
        addv(0, 1, 1, 0, 0,   0, 0,   0,   0,  1, 1);
        // Sustained saturating up count.
        addv(0, 0, 1, 0, 7,   0, 0,   1,   0,  0, 0);
        addv(0, 0, 1, 1, 7,   1, 5,   0,   5,  0, 0);
        addv(0, 1, 1, 1, 7,   0, 0,   0,   6,  0, 0);
        addv(0, 1, 1, 1, 7,   0, 0,   0,   7,  0, 0);
        addv(0, 1, 1, 1, 7,   0, 0,   0,   7,  1, 0);
        addv(0, 1, 1, 1, 7,   0, 0,   0,   7,  1, 0);
        // Down wrap from zero, then limit lowered below the count.
        addv(0, 0, 0, 0, 7,   1, 0,   0,   0,  0, 0);
        addv(0, 1, 0, 0, 7,   0, 0,   0,   7,  1, 1);
        addv(0, 1, 0, 0, 3,   0, 0,   0,   6,  0, 1);
        addv(0, 1, 1, 1, 3,   0, 0,   0,   3,  1, 1);
        // Reset mid-count leaves no tc behind.
        addv(1, 1, 1, 1, 3,   0, 0,   0,   0,  0, 0);
        addv(0, 0, 1, 0, 3,   0, 0,   0,   0,  0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].ud, vecs[i].md,
                  vecs[i].lim, vecs[i].ld, vecs[i].lv, vecs[i].clr);
            step();
            check($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_tc, vecs[i].e_ovf);
        end

        // Randomized phase against the model.
        drive(1, 0, 1, 0, 20, 0, 0, 0);
        model_edge();
        step();
        check("rand_reset", m_cnt, m_tc, m_ovf);
        for (int c = 0; c < 3000; c++) begin
            int lim_sel;
            lim_sel = int'($urandom_range(0, 9));
            reset      = ($urandom_range(0, 99) < 2);
            load       = ($urandom_range(0, 99) < 8);
            enable     = ($urandom_range(0, 99) < 80);
            ovf_clr    = ($urandom_range(0, 99) < 10);
            load_value = W'($urandom_range(0, 255));
            if (($urandom_range(0, 99)) < 10) up_down = ~up_down;
            if (($urandom_range(0, 99)) < 5)  mode    = ~mode;
            if (($urandom_range(0, 99)) < 3) begin
                case (lim_sel)
                    0:       limit = 8'd0;
                    1:       limit = 8'd255;
                    2:       limit = 8'd1;
                    default: limit = W'($urandom_range(2, 30));
                endcase
            end
            model_edge();
            step();
            check($sformatf("rand%0d", c), m_cnt, m_tc, m_ovf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_param_updown_counter

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the sole clock, and reset is sampled only on the rising edge of clk.
REQ-002 Parameter WIDTH, default 8: counter width in bits; legal range 2..32.
REQ-003 Port clk, input, 1: rising-edge clock.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port enable, input, 1: count enable; when low, the counter holds.
REQ-006 Port up_down, input, 1: 1 counts up, 0 counts down.
REQ-007 Port mode, input, 1: 0 selects wrap, 1 selects saturate.
REQ-008 Port limit, input, WIDTH: inclusive upper bound; the count range is 0..limit.
REQ-009 Port load, input, 1: synchronous load strobe.
REQ-010 Port load_value, input, WIDTH: value to load.
REQ-011 Port ovf_clr, input, 1: clears the sticky overflow flag.
REQ-012 Port count_out, output, WIDTH: registered count.
REQ-013 Port tc, output, 1: registered terminal-count pulse.
REQ-014 Port ovf, output, 1: registered sticky wrap flag.

Function
REQ-015 Update priority at each clk edge SHALL be: reset, then load, then enabled count, then hold.
REQ-016 Load SHALL set count_out to min(load_value, limit); tc SHALL be 0 in the following cycle; ovf SHALL be unaffected except by ovf_clr.
REQ-017 Up count with count_out < limit SHALL set count_out to count_out+1.
REQ-018 Up count with count_out >= limit SHALL be a boundary event: wrap mode sets count_out to 0; saturate mode sets count_out to limit.
REQ-019 Down count with count_out > 0 SHALL set count_out to count_out-1.
REQ-020 Down count with count_out == 0 SHALL be a boundary event: wrap mode sets count_out to limit; saturate mode holds 0.
REQ-021 A down count with count_out > limit (limit lowered mid-count) SHALL decrement normally, with no clamping.
REQ-022 tc SHALL be 1 for exactly the cycle after each boundary event, coincident with the post-boundary count_out value, and 0 otherwise; zero-latency combinational tc is forbidden.
REQ-023 In saturate mode, a sustained enabled count at the boundary SHALL assert tc every cycle.
REQ-024 ovf SHALL set on a boundary event in wrap mode only and SHALL clear on ovf_clr; if set and clear coincide, set SHALL win.
REQ-025 With limit == 0, count_out SHALL stay 0, and every enabled count SHALL be a boundary event.
REQ-026 Changes to up_down, mode or limit SHALL take effect at the next clk edge; the block SHALL have no internal pipeline.
REQ-027 Arithmetic SHALL be performed at WIDTH+1 bits internally, so that up_count at all-ones never silently aliases.

Reset
REQ-028 On reset, count_out SHALL become 0 if up_down == 1, or limit if up_down == 0; tc and ovf SHALL become 0.
REQ-029 Reset SHALL override a coincident load, enable or ovf_clr in the same cycle.
REQ-030 Reset asserted mid-count SHALL take effect at the next edge, with no residual tc pulse.

Structure
REQ-031 A shared package SHALL hold the mode encodings MODE_WRAP=0 and MODE_SAT=1 and the default WIDTH constant.
REQ-032 Next-value and boundary detection SHALL live in one combinational sub-module, updown_next; the top level holds only the three registers.
REQ-033 The RTL SHALL be 120-400 lines total.

Verification (WIDTH=8)
REQ-034 reset, up_down=1, then 4 enabled cycles -> count_out 0,1,2,3,4; tc=0.
REQ-035 limit=9, mode=0, up, from count 8, 2 enables -> count_out 9, then 0 with tc=1 for one cycle and ovf=1.
REQ-036 limit=9, mode=1, down, from count 1, 3 enables -> count_out 0,0,0; tc=0,1,1; ovf=0.
REQ-037 load=1, load_value=200, limit=50 -> count_out=50; same-cycle reset=1 and up_down=0 -> count_out=limit instead.
REQ-038 ovf=1, then ovf_clr=1 coincident with a wrap event -> ovf stays 1; ovf_clr alone on the next cycle -> ovf=0.
REQ-039 limit=255, mode=0, up, from count 255 -> count_out=0, tc=1; then limit=0 with 3 enables -> count_out=0 and tc=1 each cycle.
